// File: rtl/bsg_manycore_host_arb_pkg.sv
// Shared types and constants for the manycore host-link credit arbiter.
package bsg_manycore_host_arb_pkg;

   typedef enum logic [1:0] {
      StWaitReset = 2'd0,
      StReady     = 2'd1,
      StSend      = 2'd2,
      StFence     = 2'd3
   } host_arb_state_e;

   localparam int unsigned stats_width_gp = 32;

   // Next round-robin pointer after a grant to index idx.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: the lowest requesting index at or above the pointer wins, with wrap.
module bsg_arb_round_robin
   import bsg_manycore_host_arb_pkg::*;
#(
   parameter int unsigned width_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] reqs_i,
   output logic [width_p-1:0] grants_o,
   input  logic               yumi_i
);

   localparam int unsigned ptr_width_lp = (width_p > 1) ? $clog2(width_p) : 1;

   logic [ptr_width_lp-1:0] r_ptr;
   logic [ptr_width_lp-1:0] w_ptr_next;
   logic [ptr_width_lp-1:0] w_winner;
   logic [ptr_width_lp:0]   w_idx;
   logic                    w_found;

   always_comb begin
      grants_o = '0;
      w_winner = '0;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int unsigned i = 0; i < width_p; i++) begin
         w_idx = {1'b0, r_ptr} + (ptr_width_lp + 1)'(i);
         if (w_idx >= (ptr_width_lp + 1)'(width_p)) begin
            w_idx = w_idx - (ptr_width_lp + 1)'(width_p);
         end
         if (!w_found && reqs_i[w_idx[ptr_width_lp-1:0]]) begin
            grants_o[w_idx[ptr_width_lp-1:0]] = 1'b1;
            w_winner = w_idx[ptr_width_lp-1:0];
            w_found  = 1'b1;
         end
      end
   end

   always_comb begin
      w_ptr_next = ptr_width_lp'(rr_next(int'(w_winner), width_p));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_ptr <= '0;
      end else if (yumi_i) begin
         r_ptr <= w_ptr_next;
      end
   end

endmodule

// File: rtl/bsg_manycore_host_credit_arbiter.sv
// Arbitrates host requesters onto the credit-limited manycore host link, with fence support.
// Optional statistics counters are built when BSG_MACHINE_HOST_ARB_STATS_EN is defined.
module bsg_manycore_host_credit_arbiter
   import bsg_manycore_host_arb_pkg::*;
#(
   parameter int unsigned num_req_p      = 2,
   parameter int unsigned packet_width_p = 128,
   parameter int unsigned max_credits_p  = 32,
   localparam int unsigned credit_width_lp = $clog2(max_credits_p + 1)
) (
   input  logic                                      clk_i,
   input  logic                                      reset_i,
   input  logic                                      reset_done_i,
   input  logic [num_req_p-1:0]                      req_v_i,
   input  logic [num_req_p-1:0][packet_width_p-1:0]  req_packet_i,
   output logic [num_req_p-1:0]                      req_ready_o,
   output logic                                      packet_v_o,
   output logic [packet_width_p-1:0]                 packet_o,
   input  logic                                      packet_ready_i,
   input  logic                                      credit_return_i,
   input  logic                                      fence_i,
   output logic                                      fence_done_o,
   output logic [credit_width_lp-1:0]                credits_used_o,
   output logic                                      underflow_o
`ifdef BSG_MACHINE_HOST_ARB_STATS_EN
   ,
   output logic [num_req_p-1:0][stats_width_gp-1:0]  grant_count_o,
   output logic [stats_width_gp-1:0]                 stall_count_o
`endif
);

   localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_credits_p);
   localparam logic [credit_width_lp-1:0] one_credit_lp  = credit_width_lp'(1);

   host_arb_state_e              r_state, w_state_next;
   logic [credit_width_lp-1:0]   r_credits, w_credits_next;
   logic                         r_underflow, w_underflow_set;
   logic [packet_width_p-1:0]    r_packet, w_packet_sel;
   logic                         w_grant_en;
   logic [num_req_p-1:0]         w_grants;
   logic                         w_accept;

   // Only the registered count gates grants, so a same-cycle return cannot open a slot.
   assign w_grant_en = (r_state == StReady) && !fence_i && (r_credits < max_credits_lp);

   bsg_arb_round_robin #(
      .width_p (num_req_p)
   ) u_rr (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .reqs_i   (req_v_i & {num_req_p{w_grant_en}}),
      .grants_o (w_grants),
      .yumi_i   (w_accept)
   );

   assign w_accept       = |w_grants;
   assign req_ready_o    = w_grants;
   assign packet_v_o     = (r_state == StSend);
   assign packet_o       = r_packet;
   assign credits_used_o = r_credits;
   assign underflow_o    = r_underflow;
   assign fence_done_o   = (r_state == StFence) && (r_credits == '0);

   always_comb begin
      w_packet_sel = '0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         if (w_grants[i]) begin
            w_packet_sel = req_packet_i[i];
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StWaitReset: begin
            if (reset_done_i) w_state_next = StReady;
         end
         StReady: begin
            if (fence_i) w_state_next = StFence;
            else if (w_accept) w_state_next = StSend;
         end
         StSend: begin
            if (packet_ready_i) w_state_next = fence_i ? StFence : StReady;
         end
         StFence: begin
            if (r_credits == '0) w_state_next = StReady;
         end
         default: w_state_next = StWaitReset;
      endcase
   end

   always_comb begin
      w_credits_next  = r_credits;
      w_underflow_set = 1'b0;
      if (w_accept && !credit_return_i) begin
         w_credits_next = r_credits + one_credit_lp;
      end else if (!w_accept && credit_return_i) begin
         if (r_credits == '0) w_underflow_set = 1'b1;
         else w_credits_next = r_credits - one_credit_lp;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state     <= StWaitReset;
         r_credits   <= '0;
         r_underflow <= 1'b0;
         r_packet    <= '0;
      end else begin
         r_state     <= w_state_next;
         r_credits   <= w_credits_next;
         r_underflow <= r_underflow | w_underflow_set;
         if (w_accept) r_packet <= w_packet_sel;
      end
   end

`ifdef BSG_MACHINE_HOST_ARB_STATS_EN
   logic [num_req_p-1:0][stats_width_gp-1:0] r_grant_count;
   logic [stats_width_gp-1:0]                r_stall_count;
   logic                                     w_stall;

   assign w_stall       = (r_state == StReady) && (|req_v_i) && !w_accept;
   assign grant_count_o = r_grant_count;
   assign stall_count_o = r_stall_count;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_grant_count <= '0;
         r_stall_count <= '0;
      end else begin
         for (int unsigned i = 0; i < num_req_p; i++) begin
            if (w_grants[i]) r_grant_count[i] <= r_grant_count[i] + stats_width_gp'(1);
         end
         if (w_stall) r_stall_count <= r_stall_count + stats_width_gp'(1);
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bsg_manycore_host_credit_arbiter.sv
// Directed self-checking bench for bsg_manycore_host_credit_arbiter (2 requesters, 4 credits).
module tb_bsg_manycore_host_credit_arbiter;

   localparam int unsigned NumReq  = 2;
   localparam int unsigned PktW    = 32;
   localparam int unsigned MaxCred = 4;
   localparam int unsigned CredW   = $clog2(MaxCred + 1);

   logic                         clk_i = 1'b0;
   logic                         reset_i;
   logic                         reset_done_i;
   logic [NumReq-1:0]            req_v_i;
   logic [NumReq-1:0][PktW-1:0]  req_packet_i;
   logic [NumReq-1:0]            req_ready_o;
   logic                         packet_v_o;
   logic [PktW-1:0]              packet_o;
   logic                         packet_ready_i;
   logic                         credit_return_i;
   logic                         fence_i;
   logic                         fence_done_o;
   logic [CredW-1:0]             credits_used_o;
   logic                         underflow_o;

   int n_checks = 0;
   int n_errors = 0;

   bsg_manycore_host_credit_arbiter #(
      .num_req_p      (NumReq),
      .packet_width_p (PktW),
      .max_credits_p  (MaxCred)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .reset_done_i    (reset_done_i),
      .req_v_i         (req_v_i),
      .req_packet_i    (req_packet_i),
      .req_ready_o     (req_ready_o),
      .packet_v_o      (packet_v_o),
      .packet_o        (packet_o),
      .packet_ready_i  (packet_ready_i),
      .credit_return_i (credit_return_i),
      .fence_i         (fence_i),
      .fence_done_o    (fence_done_o),
      .credits_used_o  (credits_used_o),
      .underflow_o     (underflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(negedge clk_i);
   endtask

   // Leaves the bench at a falling edge with reset just released and the DUT in WAIT_RESET.
   task automatic do_reset(input logic done);
      tick();
      reset_i = 1'b1;
      reset_done_i = 1'b0;
      req_v_i = '0;
      req_packet_i = '0;
      packet_ready_i = 1'b0;
      credit_return_i = 1'b0;
      fence_i = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
      reset_done_i = done;
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      req_v_i = 2'b11;
      #1;
      n_checks++;
      if (req_ready_o !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_req_ready: got %b expected 00", req_ready_o);
      end
      n_checks++;
      if ({packet_v_o, fence_done_o, underflow_o} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_flags: got %b expected 000", {packet_v_o, fence_done_o, underflow_o});
      end
      n_checks++;
      if (credits_used_o !== '0) begin
         n_errors++;
         $display("FAIL reset_credits: got %0d expected 0", credits_used_o);
      end
   endtask

   task automatic test_wait_reset();
      int bad;
      bad = 0;
      do_reset(1'b0);
      req_v_i = 2'b11;
      packet_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         #1;
         if (req_ready_o !== 2'b00) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_errors++;
         $display("FAIL wait_reset_no_grant: got %0d grant cycles expected 0", bad);
      end
      reset_done_i = 1'b1;
      #1;
      n_checks++;
      if (req_ready_o !== 2'b00) begin
         n_errors++;
         $display("FAIL wait_reset_same_cycle: got %b expected 00", req_ready_o);
      end
      tick();
      #1;
      n_checks++;
      if (req_ready_o !== 2'b01) begin
         n_errors++;
         $display("FAIL wait_reset_first_grant: got %b expected 01", req_ready_o);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]    exp_grant;
      logic [PktW-1:0] exp_pkt;
      do_reset(1'b1);
      req_v_i = 2'b11;
      packet_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         req_packet_i[0] = 32'h1000_0000 | k;
         req_packet_i[1] = 32'h2000_0000 | k;
         #1;
         exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_pkt = (k % 2 == 0) ? (32'h1000_0000 | k) : (32'h2000_0000 | k);
         n_checks++;
         if (req_ready_o !== exp_grant) begin
            n_errors++;
            $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready_o, exp_grant);
         end
         tick();
         #1;
         n_checks++;
         if (packet_v_o !== 1'b1 || packet_o !== exp_pkt || req_ready_o !== 2'b00) begin
            n_errors++;
            $display("FAIL rr_send[%0d]: got v=%b pkt=%h rdy=%b expected v=1 pkt=%h rdy=00",
                     k, packet_v_o, packet_o, req_ready_o, exp_pkt);
         end
         n_checks++;
         if (credits_used_o !== CredW'(k + 1)) begin
            n_errors++;
            $display("FAIL rr_credits[%0d]: got %0d expected %0d", k, credits_used_o, k + 1);
         end
      end
   endtask

   task automatic test_credit_limit();
      int acc;
      acc = 0;
      do_reset(1'b1);
      req_v_i = 2'b11;
      packet_ready_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         #1;
         if (|req_ready_o) acc++;
      end
      n_checks++;
      if (acc !== 4 || credits_used_o !== CredW'(4)) begin
         n_errors++;
         $display("FAIL limit_accepts: got %0d accepts count %0d expected 4 accepts count 4",
                  acc, credits_used_o);
      end
      tick();
      credit_return_i = 1'b1;
      #1;
      n_checks++;
      if (req_ready_o !== 2'b00) begin
         n_errors++;
         $display("FAIL limit_return_same_cycle: got %b expected 00", req_ready_o);
      end
      acc = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         credit_return_i = 1'b0;
         #1;
         if (|req_ready_o) acc++;
      end
      n_checks++;
      if (acc !== 1 || credits_used_o !== CredW'(4)) begin
         n_errors++;
         $display("FAIL limit_after_return: got %0d accepts count %0d expected 1 accepts count 4",
                  acc, credits_used_o);
      end
   endtask

   task automatic test_send_hold();
      int bad;
      bad = 0;
      do_reset(1'b1);
      tick();
      req_v_i = 2'b01;
      req_packet_i[0] = 32'hCAFE_0001;
      #1;
      n_checks++;
      if (req_ready_o !== 2'b01) begin
         n_errors++;
         $display("FAIL hold_accept: got %b expected 01", req_ready_o);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         req_packet_i[0] = 32'h0BAD_0000 | i;
         #1;
         if (packet_o !== 32'hCAFE_0001 || packet_v_o !== 1'b1 || req_ready_o !== 2'b00) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_errors++;
         $display("FAIL hold_stable: got %0d bad cycles expected 0", bad);
      end
      packet_ready_i = 1'b1;
      tick();
      credit_return_i = 1'b1;
      #1;
      n_checks++;
      if (req_ready_o !== 2'b01) begin
         n_errors++;
         $display("FAIL hold_accept_with_return: got %b expected 01", req_ready_o);
      end
      tick();
      credit_return_i = 1'b0;
      req_v_i = 2'b00;
      #1;
      n_checks++;
      if (credits_used_o !== CredW'(1) || packet_o !== 32'h0BAD_0004) begin
         n_errors++;
         $display("FAIL hold_same_cycle_count: got count %0d pkt %h expected count 1 pkt 0bad0004",
                  credits_used_o, packet_o);
      end
      tick();
      credit_return_i = 1'b1;
      tick();
      credit_return_i = 1'b0;
      #1;
      n_checks++;
      if (credits_used_o !== CredW'(0) || underflow_o !== 1'b0) begin
         n_errors++;
         $display("FAIL hold_return_only: got count %0d uf %b expected count 0 uf 0",
                  credits_used_o, underflow_o);
      end
   endtask

   task automatic test_fence();
      int pulses;
      pulses = 0;
      do_reset(1'b1);
      req_v_i = 2'b01;
      packet_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      fence_i = 1'b1;
      tick();
      credit_return_i = 1'b1;
      #1;
      n_checks++;
      if (req_ready_o !== 2'b00 || credits_used_o !== CredW'(3) || fence_done_o !== 1'b0) begin
         n_errors++;
         $display("FAIL fence_enter: got rdy %b count %0d done %b expected rdy 00 count 3 done 0",
                  req_ready_o, credits_used_o, fence_done_o);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         #1;
         if (fence_done_o !== 1'b0 || req_ready_o !== 2'b00) pulses++;
      end
      tick();
      credit_return_i = 1'b0;
      #1;
      n_checks++;
      if (pulses !== 0 || fence_done_o !== 1'b1 || credits_used_o !== CredW'(0)) begin
         n_errors++;
         $display("FAIL fence_done_pulse: got early %0d done %b count %0d expected 0 1 0",
                  pulses, fence_done_o, credits_used_o);
      end
      fence_i = 1'b0;
      tick();
      #1;
      n_checks++;
      if (fence_done_o !== 1'b0 || req_ready_o !== 2'b01) begin
         n_errors++;
         $display("FAIL fence_resume: got done %b rdy %b expected done 0 rdy 01",
                  fence_done_o, req_ready_o);
      end
   endtask

   task automatic test_underflow_reset();
      do_reset(1'b1);
      tick();
      credit_return_i = 1'b1;
      tick();
      credit_return_i = 1'b0;
      #1;
      n_checks++;
      if (underflow_o !== 1'b1 || credits_used_o !== CredW'(0)) begin
         n_errors++;
         $display("FAIL underflow_set: got uf %b count %0d expected uf 1 count 0",
                  underflow_o, credits_used_o);
      end
      for (int i = 0; i < 3; i++) tick();
      req_v_i = 2'b01;
      req_packet_i[0] = 32'h5555_AAAA;
      #1;
      n_checks++;
      if (underflow_o !== 1'b1 || req_ready_o !== 2'b01) begin
         n_errors++;
         $display("FAIL underflow_sticky: got uf %b rdy %b expected uf 1 rdy 01",
                  underflow_o, req_ready_o);
      end
      tick();
      reset_i = 1'b1;
      #1;
      n_checks++;
      if (packet_v_o !== 1'b1 || credits_used_o !== CredW'(1)) begin
         n_errors++;
         $display("FAIL mid_send_state: got v %b count %0d expected v 1 count 1",
                  packet_v_o, credits_used_o);
      end
      tick();
      #1;
      n_checks++;
      if ({packet_v_o, fence_done_o, underflow_o} !== 3'b000 || req_ready_o !== 2'b00 ||
          credits_used_o !== CredW'(0)) begin
         n_errors++;
         $display("FAIL mid_send_reset: got v/done/uf %b rdy %b count %0d expected 000 00 0",
                  {packet_v_o, fence_done_o, underflow_o}, req_ready_o, credits_used_o);
      end
   endtask

   initial begin
      reset_i = 1'b1;
      reset_done_i = 1'b0;
      req_v_i = '0;
      req_packet_i = '0;
      packet_ready_i = 1'b0;
      credit_return_i = 1'b0;
      fence_i = 1'b0;
      test_reset();
      test_wait_reset();
      test_round_robin();
      test_credit_limit();
      test_send_hold();
      test_fence();
      test_underflow_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_host_credit_arbiter.md
BSG_MANYCORE_HOST_CREDIT_ARBITER -- requirements
Module: bsg_manycore_host_credit_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2, number of host requesters (DPI fifo, config sequencer, ...), legal range 2..8.
REQ-002 SHALL have parameter packet_width_p, default 128, manycore request packet width.
REQ-003 SHALL have parameter max_credits_p, default 32, maximum outstanding host-link requests.
REQ-004 SHALL have port clk_i, input, 1, the only clock.
REQ-005 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port reset_done_i, input, 1, tag programming complete; no grants are issued before it is high.
REQ-007 SHALL have port req_v_i, input, num_req_p, per-requester valid.
REQ-008 SHALL have port req_packet_i, input, num_req_p x packet_width_p, per-requester packet.
REQ-009 SHALL have port req_ready_o, output, num_req_p, one-hot grant/accept.
REQ-010 SHALL have port packet_v_o, input-side valid toward the link: output, 1.
REQ-011 SHALL have port packet_o, output, packet_width_p, registered packet to the host link.
REQ-012 SHALL have port packet_ready_i, input, 1, link accepts packet_o.
REQ-013 SHALL have port credit_return_i, input, 1, one returned response credit per cycle.
REQ-014 SHALL have port fence_i, input, 1, level request to drain all outstanding credits.
REQ-015 SHALL have port fence_done_o, output, 1, one-cycle pulse when the fence completes.
REQ-016 SHALL have port credits_used_o, output, clog2(max_credits_p+1), outstanding count.
REQ-017 SHALL have port underflow_o, output, 1, sticky credit-underflow error.

Function
REQ-018 FSM states SHALL be WAIT_RESET, READY, SEND, FENCE.
REQ-019 WAIT_RESET -> READY SHALL occur on the first cycle reset_done_i=1.
REQ-020 In READY, req_ready_o[i] SHALL be 1 only for the round-robin winner i, with req_v_i[i]=1, credits_used_o<max_credits_p and fence_i=0; all other bits SHALL be 0, including in every other state.
REQ-021 On accept (req_v_i[i]&req_ready_o[i]), the packet SHALL be captured, credits_used_o SHALL increment, and the state SHALL become SEND; packet_v_o SHALL be 1 in the next cycle (latency 1).
REQ-022 In SEND, packet_o SHALL be held stable until packet_ready_i=1; the state SHALL then become READY (or FENCE if fence_i=1), giving at most one accept per 2 cycles.
REQ-023 The round-robin pointer SHALL reset to 0 and, after a grant to i, SHALL become (i+1) mod num_req_p; the lowest index at or above the pointer wins.
REQ-024 credit_return_i SHALL decrement credits_used_o; an accept and a return in the same cycle SHALL leave the count unchanged.
REQ-025 A return with credits_used_o=0 and no same-cycle accept SHALL hold the count at 0 and set underflow_o until reset.
REQ-026 READY with fence_i=1 SHALL go to FENCE; FENCE SHALL exit to READY, pulsing fence_done_o, on the cycle credits_used_o=0.
REQ-027 At credits_used_o=max_credits_p, no grant SHALL be issued; a same-cycle return SHALL NOT enable a same-cycle grant.

Reset
REQ-028 reset_i SHALL force WAIT_RESET, pointer=0, credits_used_o=0, packet_v_o=0, req_ready_o=0, fence_done_o=0, underflow_o=0; reset mid-SEND SHALL drop the held packet.

Configuration
REQ-029 With BSG_MACHINE_HOST_ARB_STATS_EN defined, the block SHALL add output grant_count_o (num_req_p x 32, a per-requester accept counter that wraps) and stall_count_o (32, cycles spent in READY with some req_v_i=1 and no grant); both SHALL reset to 0.
REQ-030 Without BSG_MACHINE_HOST_ARB_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-031 The FSM state enum and the stats counter width (32) SHALL live in bsg_manycore_host_arb_pkg.
REQ-032 Arbitration SHALL use one sub-module instance, bsg_arb_round_robin; the credit counter and FSM SHALL be local.

Verification
REQ-033 reset_done_i held 0 for 10 cycles with req_v_i=2'b11 -> no req_ready_o; a grant to req 0 follows in the first cycle after reset_done_i=1.
REQ-034 Both requesters always valid, packet_ready_i=1 -> grant order 0,1,0,1; packet_v_o 1 cycle after each accept; credits_used_o rises 1..4.
REQ-035 max_credits_p=4, no returns -> exactly 4 accepts, then stall; one credit_return_i pulse -> exactly one further accept, never in the same cycle as the return.
REQ-036 packet_ready_i=0 for 5 cycles in SEND -> packet_o stable, no req_ready_o; accept and return in the same cycle -> count unchanged.
REQ-037 3 outstanding, fence_i=1 -> no grants; after 3 returns, fence_done_o pulses once and grants resume when fence_i=0.
REQ-038 credit_return_i at count 0 -> underflow_o=1 and stays 1; reset_i mid-SEND -> all outputs at their reset values the next cycle.
